// File: rtl/sd_fifo_pkg.sv
// Shared definitions for the SD-side FIFO reader: state encoding, block size
// default and the byte-parity ordering used by the FIFO write side.
package sd_fifo_pkg;

   localparam int DEF_MAX_BLK_WORDS = 128;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_SEND    = 3'd2;
   localparam logic [2:0] ST_BLK_END = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // Set: parity of byte[7:0] lands in dop bit 3, byte[31:24] in bit 0.
   localparam bit PAR_BYTE0_MSB = 1'b1;

endpackage

// File: rtl/sd_byte_parity.sv
// Even byte parity of a 32-bit word, packed in the same nibble order the
// FIFO write side uses for its dop lane.
module sd_byte_parity
   import sd_fifo_pkg::*;
(
   input  logic [31:0] data,
   output logic [3:0]  par
);

   for (genvar i = 0; i < 4; i++) begin : g_byte
      localparam int POS = PAR_BYTE0_MSB ? (3 - i) : i;
      assign par[POS] = ^data[8*i +: 8];
   end

endmodule

// File: rtl/sd_fifo_reader.sv
// Pops words from the AXI-to-SD FWFT FIFO and hands them one at a time to the
// SD data serializer, framed into blocks, with per-word byte-parity checking.
module sd_fifo_reader
   import sd_fifo_pkg::*;
#(
   parameter int MAX_BLK_WORDS = DEF_MAX_BLK_WORDS,
   parameter int BLK_CNT_W     = 16
) (
   input  logic                 sd_clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [7:0]           blk_words_i,
   input  logic [BLK_CNT_W-1:0] blk_cnt_i,
   input  logic [31:0]          fifo_dout_i,
   input  logic [3:0]           fifo_dop_i,
   input  logic                 fifo_empty_i,
   output logic                 fifo_rd_en_o,
   output logic [31:0]          tx_data_o,
   output logic                 tx_valid_o,
   output logic                 tx_last_o,
   input  logic                 tx_ready_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 par_err_o
);

   localparam logic [7:0] FULL_BLK = 8'(MAX_BLK_WORDS);

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [7:0]           word_idx;
   logic [7:0]           blk_words;
   logic [BLK_CNT_W-1:0] blk_rem;
   logic [3:0]           par_calc;
   logic                 accept_start;
   logic                 pop;
   logic                 last_word;
   logic                 last_blk;

   sd_byte_parity u_parity (
      .data (fifo_dout_i),
      .par  (par_calc)
   );

   // Abort wins over start, so a coincident start/abort in IDLE is dropped.
   assign accept_start = (state == ST_IDLE) && start_i && !abort_i;
   assign pop          = (state == ST_FETCH) && !fifo_empty_i && !abort_i;
   assign last_word    = (word_idx == blk_words - 8'd1);
   assign last_blk     = (blk_rem <= BLK_CNT_W'(1));

   always_comb begin
      state_nxt = state;
      if (abort_i && (state != ST_IDLE)) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (accept_start) state_nxt = (blk_cnt_i == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH:   if (!fifo_empty_i) state_nxt = ST_SEND;
            ST_SEND: begin
               if (tx_ready_i) begin
                  if (!last_word)    state_nxt = ST_FETCH;
                  else if (last_blk) state_nxt = ST_DONE;
                  else               state_nxt = ST_BLK_END;
               end
            end
            ST_BLK_END: state_nxt = ST_FETCH;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sd_clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         word_idx  <= '0;
         blk_words <= '0;
         blk_rem   <= '0;
         tx_data_o <= '0;
         par_err_o <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept_start) begin
            blk_words <= (blk_words_i == 8'd0) ? FULL_BLK : blk_words_i;
            blk_rem   <= blk_cnt_i;
            word_idx  <= '0;
            par_err_o <= 1'b0;
         end
         // The parity flag is informational only; the transfer never stalls on it.
         if (pop) begin
            tx_data_o <= fifo_dout_i;
            if (par_calc != fifo_dop_i) par_err_o <= 1'b1;
         end
         if ((state == ST_SEND) && tx_ready_i && !abort_i && !last_word) begin
            word_idx <= word_idx + 8'd1;
         end
         if ((state == ST_BLK_END) && !abort_i) begin
            word_idx <= '0;
            if (blk_rem != '0) blk_rem <= blk_rem - BLK_CNT_W'(1);
         end
      end
   end

   assign fifo_rd_en_o = pop;
   assign tx_valid_o   = (state == ST_SEND);
   assign tx_last_o    = (state == ST_SEND) && last_word;
   assign busy_o       = (state != ST_IDLE);
   assign done_o       = (state == ST_DONE);

endmodule
